// File: rtl/if_id_skid_reg_if.sv
// IF/ID elastic register bus bundle.
// Fetch-side and decode-side handshakes plus status.
interface if_id_skid_reg_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int EXC_W   = 5,
  parameter int CNT_W   = 16
) ();
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_PC;
  logic [INSTR_W-1:0] in_instruction;
  logic [EXC_W-1:0]   in_exc;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_PC;
  logic [INSTR_W-1:0] out_instruction;
  logic [EXC_W-1:0]   out_exc;
  logic [1:0]         occupancy;
  logic [CNT_W-1:0]   bp_count;

  modport slave (
    input  in_valid, in_PC, in_instruction, in_exc,
    input  out_ready,
    output in_ready, out_valid, out_PC,
    output out_instruction, out_exc,
    output occupancy, bp_count
  );

  modport master (
    output in_valid, in_PC, in_instruction, in_exc,
    output out_ready,
    input  in_ready, out_valid, out_PC,
    input  out_instruction, out_exc,
    input  occupancy, bp_count
  );
endinterface

// File: rtl/if_id_skid_reg.sv
// Elastic IF/ID register: main + skid entry,
// registered upstream ready, flush, bp counter.
module if_id_skid_reg #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int EXC_W   = 5,
  parameter logic [PC_W-1:0] RESET_PC = 'h3000,
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic reset,
  input logic flush,
  if_id_skid_reg_if.slave bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_out_valid;
  logic               r_in_ready;
  logic [PC_W-1:0]    r_main_pc;
  logic [INSTR_W-1:0] r_main_ins;
  logic [EXC_W-1:0]   r_main_exc;
  logic [PC_W-1:0]    r_skid_pc;
  logic [INSTR_W-1:0] r_skid_ins;
  logic [EXC_W-1:0]   r_skid_exc;
  logic [CNT_W-1:0]   r_bp;
  logic               w_accept;
  logic               w_consume;
  logic               w_clear;

  assign w_accept  = bus.in_valid & r_in_ready;
  assign w_consume = r_out_valid & bus.out_ready;
  assign w_clear   = reset | flush;

  // State register; valid/ready are precomputed
  // from the next state so both stay registered.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_next;
      r_out_valid <= (w_next != S_EMPTY);
      r_in_ready  <= (w_next != S_FULL);
    end
  end

  // Next-state decode from accept/consume.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_EMPTY: if (w_accept) w_next = S_ONE;
      S_ONE: begin
        if (w_accept && !w_consume)
          w_next = S_FULL;
        else if (!w_accept && w_consume)
          w_next = S_EMPTY;
      end
      S_FULL: if (w_consume) w_next = S_ONE;
      default: w_next = S_EMPTY;
    endcase
  end

  // Main/skid datapath; a drained main keeps
  // its PC but shows a nop with no exception.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_main_pc  <= RESET_PC;
      r_main_ins <= '0;
      r_main_exc <= '0;
      r_skid_pc  <= '0;
      r_skid_ins <= '0;
      r_skid_exc <= '0;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_main_pc  <= bus.in_PC;
            r_main_ins <= bus.in_instruction;
            r_main_exc <= bus.in_exc;
          end
        end
        S_ONE: begin
          if (w_accept && w_consume) begin
            r_main_pc  <= bus.in_PC;
            r_main_ins <= bus.in_instruction;
            r_main_exc <= bus.in_exc;
          end else if (w_accept) begin
            r_skid_pc  <= bus.in_PC;
            r_skid_ins <= bus.in_instruction;
            r_skid_exc <= bus.in_exc;
          end else if (w_consume) begin
            r_main_ins <= '0;
            r_main_exc <= '0;
          end
        end
        S_FULL: begin
          if (w_consume) begin
            r_main_pc  <= r_skid_pc;
            r_main_ins <= r_skid_ins;
            r_main_exc <= r_skid_exc;
            r_skid_pc  <= '0;
            r_skid_ins <= '0;
            r_skid_exc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating count of blocked fetch cycles;
  // survives flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)
      r_bp <= '0;
    else if (!flush && bus.in_valid &&
             !r_in_ready &&
             (r_bp != {CNT_W{1'b1}}))
      r_bp <= r_bp + 1'b1;
  end

  // Outputs come straight from registers.
  always_comb begin
    bus.in_ready        = r_in_ready;
    bus.out_valid       = r_out_valid;
    bus.out_PC          = r_main_pc;
    bus.out_instruction = r_main_ins;
    bus.out_exc         = r_main_exc;
    bus.occupancy       = r_state;
    bus.bp_count        = r_bp;
  end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: queue model,
// directed cases then random traffic.
module tb_if_id_skid_reg;

  localparam logic [31:0] RST_PC = 32'h3000;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  if_id_skid_reg_if #(.CNT_W(16)) ifa ();
  if_id_skid_reg_if #(.CNT_W(4))  ifb ();

  if_id_skid_reg #(.CNT_W(16)) dut_a (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (ifa.slave)
  );

  if_id_skid_reg #(.CNT_W(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (ifb.slave)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [4:0]  exc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] last_pc = RST_PC;
  logic        m_ready = 1'b1;
  int          bp = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic step(input logic v,
                      input logic [31:0] pc,
                      input logic [31:0] ins,
                      input logic [4:0] ex,
                      input logic ordy,
                      input logic fl,
                      input logic rs);
    ent_t e;
    logic acc, con;
    logic [31:0] e_pc, e_ins;
    logic [4:0] e_exc;
    int e_bp4;
    reset = rs;
    flush = fl;
    ifa.in_valid = v;       ifb.in_valid = v;
    ifa.in_PC = pc;         ifb.in_PC = pc;
    ifa.in_instruction = ins;
    ifb.in_instruction = ins;
    ifa.in_exc = ex;        ifb.in_exc = ex;
    ifa.out_ready = ordy;   ifb.out_ready = ordy;
    @(posedge clk);
    acc = v && m_ready;
    con = (q.size() > 0) && ordy;
    e.pc = pc; e.ins = ins; e.exc = ex;
    if (rs) begin
      q.delete(); last_pc = RST_PC; bp = 0;
    end else if (fl) begin
      q.delete(); last_pc = RST_PC;
    end else begin
      if (v && !m_ready) bp++;
      if (con) begin
        last_pc = q[0].pc;
        void'(q.pop_front());
      end
      if (acc) q.push_back(e);
    end
    m_ready = (q.size() < 2);
    #1;
    e_pc  = q.size() > 0 ? q[0].pc  : last_pc;
    e_ins = q.size() > 0 ? q[0].ins : 32'h0;
    e_exc = q.size() > 0 ? q[0].exc : 5'h0;
    e_bp4 = bp > 15 ? 15 : bp;
    check("out_valid", 64'(ifa.out_valid),
          64'(q.size() > 0));
    check("in_ready", 64'(ifa.in_ready),
          64'(m_ready));
    check("occupancy", 64'(ifa.occupancy),
          64'(q.size()));
    check("out_PC", 64'(ifa.out_PC), 64'(e_pc));
    check("out_instr", 64'(ifa.out_instruction),
          64'(e_ins));
    check("out_exc", 64'(ifa.out_exc), 64'(e_exc));
    check("bp16", 64'(ifa.bp_count), 64'(bp));
    check("bp4", 64'(ifb.bp_count), 64'(e_bp4));
    check("b_occ", 64'(ifb.occupancy),
          64'(q.size()));
  endtask

  task automatic feed(input int n,
                      input logic ordy);
    logic [31:0] pcs [3];
    int idx = 0;
    pcs[0] = 32'h3000;
    pcs[1] = 32'h3004;
    pcs[2] = 32'h3008;
    for (int k = 0; k < n; k++) begin
      if (idx < 3) begin
        logic take;
        take = m_ready;
        step(1'b1, pcs[idx], 32'h13 + pcs[idx],
             5'h0, ordy, 1'b0, 1'b0);
        if (take) idx++;
      end else begin
        step(1'b0, 32'h0, 32'h0, 5'h0, ordy,
             1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    // reset with in_valid high
    step(1, 32'hdead, 32'hbeef, 5'h1, 0, 0, 1);
    step(1, 32'hdead, 32'hbeef, 5'h1, 0, 0, 1);
    check("rst_pc", 64'(ifa.out_PC), 64'h3000);
    check("rst_rdy", 64'(ifa.in_ready), 64'h1);
    check("rst_vld", 64'(ifa.out_valid), 64'h0);

    // streaming
    feed(5, 1'b1);

    // back-pressure then release
    step(0, 0, 0, 0, 0, 0, 1);
    feed(5, 1'b0);
    check("bp_full", 64'(ifa.occupancy), 64'h2);
    check("bp_cnt", 64'(ifa.bp_count), 64'd3);
    feed(5, 1'b1);

    // flush while FULL with input offered
    step(0, 0, 0, 0, 0, 0, 1);
    feed(2, 1'b0);
    step(1, 32'h4444, 32'h55, 5'h2, 0, 1, 0);
    check("fl_pc", 64'(ifa.out_PC), 64'h3000);
    check("fl_occ", 64'(ifa.occupancy), 64'h0);
    check("fl_rdy", 64'(ifa.in_ready), 64'h1);
    step(0, 0, 0, 0, 1, 0, 0);
    check("fl_gone", 64'(ifa.out_valid), 64'h0);

    // drain keeps PC, zeroes instr/exc
    step(1, 32'h40, 32'h77, 5'h3, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    check("drn_pc", 64'(ifa.out_PC), 64'h40);
    check("drn_ins", 64'(ifa.out_instruction), 64'h0);

    // exception propagation
    step(1, 32'h50, 32'h99, 5'h04, 1, 0, 0);
    check("exc", 64'(ifa.out_exc), 64'h04);
    check("exc_pc", 64'(ifa.out_PC), 64'h50);

    // saturation: 2 accepts then 20 blocked
    step(0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 22; k++)
      step(1, 32'h100 + 32'(k), 32'(k), 0, 0, 0, 0);
    check("sat4", 64'(ifb.bp_count), 64'd15);
    check("sat16", 64'(ifa.bp_count), 64'd20);
    step(1, 32'h200, 0, 0, 0, 0, 0);
    check("sat4_hold", 64'(ifb.bp_count), 64'd15);

    // random traffic
    for (int k = 0; k < 600; k++)
      step($urandom_range(0, 3) != 0,
           $urandom, $urandom,
           5'($urandom_range(0, 31)),
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 40) == 0,
           $urandom_range(0, 90) == 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- Parametrised, elastic IF/ID pipeline register; successor to the fixed single-entry stall register.
- Replaces the single stall input with a valid/ready handshake on both sides, backed by a 2-entry buffer (main + skid). Upstream ready is therefore registered, with no combinational ready path.
- Adds flush (branch/exception squash), an exception-code field, bubble insertion when empty, and a saturating back-pressure counter.
- Sits between the fetch unit and the decode stage.

Parameters:
- PC_W, 32, width of PC field.
- INSTR_W, 32, width of instruction field.
- EXC_W, 5, width of fetch exception code (0 = none).
- RESET_PC, 32'h3000, value of out_PC after reset/flush.
- CNT_W, 16, width of back-pressure counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  squash all held entries this edge.
- in_valid  in  1  fetch presents a valid entry.
- in_ready  out  1  buffer accepts; registered, equals skid-empty.
- in_PC  in  PC_W  fetched PC.
- in_instruction  in  INSTR_W  fetched instruction.
- in_exc  in  EXC_W  fetch exception code.
- out_valid  out  1  decode-side entry valid.
- out_ready  in  1  decode consumes entry this edge.
- out_PC  out  PC_W  PC of main entry.
- out_instruction  out  INSTR_W  instruction of main entry; 0 (nop) whenever out_valid=0.
- out_exc  out  EXC_W  exception code of main entry; 0 whenever out_valid=0.
- occupancy  out  2  entries held: 0, 1 or 2.
- bp_count  out  CNT_W  cycles with in_valid=1 and in_ready=0; saturating.

Behaviour:
- Reset (priority 1):
  - out_valid=0, out_PC=RESET_PC, out_instruction=0, out_exc=0.
  - Skid cleared; in_ready=1, occupancy=0, bp_count=0.
- Flush (priority 2, when reset=0):
  - Same register effect as reset, except bp_count is kept.
  - Input offered in the flush cycle is dropped, even if in_valid=1 and in_ready=1.
- Transfers:
  - Accept = in_valid & in_ready.
  - Consume = out_valid & out_ready.
  - All state updates on posedge clk; 1-cycle latency from accept to out_valid.
- State EMPTY (occupancy 0):
  - accept -> ONE; main <= input.
  - else stay; out_instruction and out_exc held at 0, out_PC holds its last value.
- State ONE (occupancy 1):
  - accept & consume -> ONE; main <= input.
  - accept & !consume -> FULL; skid <= input, main unchanged.
  - !accept & consume -> EMPTY; main instruction and exc <= 0, PC kept.
  - neither -> hold.
- State FULL (occupancy 2):
  - in_ready=0; in_* inputs ignored.
  - consume -> ONE; main <= skid, skid cleared.
  - else hold.
- in_ready:
  - Registered; next value = 1 unless next state is FULL.
  - 1 after reset/flush.
- Throughput: 1 entry/cycle when out_ready is held 1. No bubble is introduced after a stall releases: FULL->ONE then ONE stays ONE.
- Ordering: strictly FIFO; no entry duplicated or lost except on flush/reset.
- bp_count: increments when in_valid & !in_ready & !flush; stops at 2^CNT_W-1 (no wrap).
- Outputs are direct register outputs; no combinational path from in_* to out_*, or from out_ready to in_ready.
- Reset asserted mid-operation (FULL) returns the block to its reset state the next edge; any skid contents are lost.
- Widths are independent; no truncation between in_* and out_* fields of the same name.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1 -> out_valid=0, out_PC=0x3000, out_instruction=0, in_ready=1, occupancy=0.
- Streaming: out_ready=1, feed PCs 0x3000, 0x3004, 0x3008 on consecutive cycles -> each appears 1 cycle later in order, out_valid stays 1, in_ready stays 1.
- Back-pressure: out_ready=0, feed 0x3000, 0x3004, 0x3008 -> occupancy 1 then 2, in_ready=0 after the second accept, 0x3008 held upstream, bp_count increments each blocked cycle. Raise out_ready -> 0x3000, 0x3004, 0x3008 delivered in order with no gaps.
- Flush while FULL with in_valid=1: -> next edge out_valid=0, occupancy=0, out_instruction=0, out_PC=0x3000, in_ready=1, offered entry absent thereafter.
- Drain: single entry consumed with no new input -> out_valid=0, out_instruction=0, out_exc=0, out_PC retains last PC.
- Saturation: CNT_W=4 with 20 blocked cycles -> bp_count=15 and holds. Exception: in_exc=5'h04 propagates to out_exc with its PC.
